// File: rtl/mine_gen_if.sv
// Request/result bundle between a board consumer and the mine placement engine.
interface mine_gen_if #(
    parameter int unsigned GRID_SIZE = 8
) ();

    localparam int unsigned TOTAL = GRID_SIZE * GRID_SIZE;
    localparam int unsigned IDX_W = $clog2(TOTAL);

    logic             gen;
    logic [IDX_W-1:0] safe_idx;
    logic [TOTAL-1:0] mine_map;
    logic             busy;
    logic             done;
    logic [8:0]       mine_count;

    // Consumer side: requests boards and reads them back.
    modport master (
        output gen,
        output safe_idx,
        input  mine_map,
        input  busy,
        input  done,
        input  mine_count
    );

    // Generator side.
    modport slave (
        input  gen,
        input  safe_idx,
        output mine_map,
        output busy,
        output done,
        output mine_count
    );

endinterface

// File: rtl/mine_gen.sv
// Pseudo-random minesweeper board generator: places NUM_MINES mines one per accepted
// LFSR candidate, never on the requested safe tile, and holds the board until the next request.
module mine_gen #(
    parameter int unsigned GRID_SIZE = 8,
    parameter int unsigned NUM_MINES = 10,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input logic       clk,
    input logic       rst,
    mine_gen_if.slave bus
);

    localparam int unsigned TOTAL     = GRID_SIZE * GRID_SIZE;
    localparam int unsigned IDX_W     = $clog2(TOTAL);
    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [8:0]  LAST_CNT  = 9'(NUM_MINES);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPlace = 2'b01,
        StDone  = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [TOTAL-1:0] map_q, map_d;
    logic [8:0]       count_q, count_d;
    logic [IDX_W-1:0] safe_q, safe_d;

    logic             lfsr_fb;
    logic [IDX_W-1:0] cand;
    logic             cand_ok;
    logic             accept;
    logic             place;
    logic [8:0]       count_inc;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, free-running in every state.
    always_comb begin
        lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
        lfsr_d  = {lfsr_q[14:0], lfsr_fb};
        // Recover from a corrupted all-zero register instead of locking up.
        if (lfsr_d == 16'h0000) begin
            lfsr_d = SEED_EFF;
        end
    end

    // Candidate qualification and request acceptance.
    always_comb begin
        cand      = lfsr_q[IDX_W-1:0];
        cand_ok   = (cand != safe_q) && !map_q[cand];
        accept    = bus.gen && ((state_q == StIdle) || (state_q == StDone));
        place     = (state_q == StPlace) && cand_ok;
        count_inc = count_q + 9'd1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; the unused encoding falls back to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StPlace;
            end
            StPlace: begin
                if (place && (count_inc == LAST_CNT)) state_d = StDone;
            end
            StDone: begin
                if (accept) state_d = StPlace;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.busy = (state_q == StPlace);
        bus.done = (state_q == StDone);
    end

    // Board datapath next-state: clear on accept, set one bit per valid placement.
    always_comb begin
        map_d   = map_q;
        count_d = count_q;
        safe_d  = safe_q;
        if (accept) begin
            map_d   = '0;
            count_d = 9'd0;
            safe_d  = bus.safe_idx;
        end else if (place) begin
            map_d[cand] = 1'b1;
            count_d     = count_inc;
        end
    end

    // Datapath and LFSR registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q  <= SEED_EFF;
            map_q   <= '0;
            count_q <= 9'd0;
            safe_q  <= '0;
        end else begin
            lfsr_q  <= lfsr_d;
            map_q   <= map_d;
            count_q <= count_d;
            safe_q  <= safe_d;
        end
    end

    assign bus.mine_map   = map_q;
    assign bus.mine_count = count_q;

endmodule

// File: tb/tb_mine_gen.sv
// Self-checking bench for mine_gen: behavioural board model plus per-cycle invariant scoreboard.
module tb_mine_gen;

    localparam int N      = 10;
    localparam int N63    = 63;
    localparam int BOUND  = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mine_gen_if #(.GRID_SIZE(8)) bus ();
    mine_gen_if #(.GRID_SIZE(8)) bus63 ();

    mine_gen #(.GRID_SIZE(8), .NUM_MINES(N), .SEED(16'hACE1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mine_gen #(.GRID_SIZE(8), .NUM_MINES(N63), .SEED(16'h0000)) u_dut63 (
        .clk (clk),
        .rst (rst),
        .bus (bus63)
    );

    int checks   = 0;
    int failures = 0;
    int cycles   = 0;

    // Reference model: phase 0 idle, 1 placing, 2 board complete.
    int          m_st;
    logic [63:0] m_map;
    int          m_cnt;
    int          m_safe;
    logic [15:0] m_lfsr;
    int          t63_safe;

    // Next LFSR value from the polynomial taps 16,14,13,11 (mask of exponents minus one).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] taps;
        taps = v & 16'hB400;
        return {v[14:0], ^taps};
    endfunction

    function automatic void model_reset();
        m_st   = 0;
        m_map  = '0;
        m_cnt  = 0;
        m_safe = 0;
        m_lfsr = 16'hACE1;
    endfunction

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        int c;
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (m_st != 1 && bus.gen) begin
                m_map  = '0;
                m_cnt  = 0;
                m_safe = int'(bus.safe_idx);
                m_st   = 1;
            end else if (m_st == 1) begin
                c = int'(m_lfsr) % 64;
                if (c != m_safe && !m_map[c]) begin
                    m_map[c] = 1'b1;
                    m_cnt++;
                    if (m_cnt == N) m_st = 2;
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
        @(negedge clk);
        cycles++;
        checks++;
        if (bus.mine_map !== m_map) begin
            failures++;
            $display("FAIL map cyc=%0d got=%h exp=%h", cycles, bus.mine_map, m_map);
        end
        checks++;
        if (bus.mine_count !== 9'(m_cnt)) begin
            failures++;
            $display("FAIL count cyc=%0d got=%0d exp=%0d", cycles, bus.mine_count, m_cnt);
        end
        checks++;
        if (bus.busy !== (m_st == 1)) begin
            failures++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cycles, bus.busy, (m_st == 1));
        end
        checks++;
        if (bus.done !== (m_st == 2)) begin
            failures++;
            $display("FAIL done cyc=%0d got=%b exp=%b", cycles, bus.done, (m_st == 2));
        end
        checks++;
        if ($countones(bus.mine_map) != int'(bus.mine_count) || bus.mine_map[m_safe] !== 1'b0
            || (bus.busy && bus.done)) begin
            failures++;
            $display("FAIL invariant cyc=%0d pop=%0d cnt=%0d safebit=%b busy=%b done=%b", cycles,
                     $countones(bus.mine_map), bus.mine_count, bus.mine_map[m_safe], bus.busy,
                     bus.done);
        end
        checks++;
        if ($countones(bus63.mine_map) != int'(bus63.mine_count)
            || bus63.mine_map[t63_safe] !== 1'b0 || (bus63.busy && bus63.done)) begin
            failures++;
            $display("FAIL invariant63 cyc=%0d pop=%0d cnt=%0d busy=%b done=%b", cycles,
                     $countones(bus63.mine_map), bus63.mine_count, bus63.busy, bus63.done);
        end
    endtask

    // Issue a one-cycle request; safe_idx is scrambled afterwards since it is only sampled once.
    task automatic start(input int s);
        bus.gen      = 1'b1;
        bus.safe_idx = 6'(s);
        tick();
        bus.gen      = 1'b0;
        bus.safe_idx = 6'($urandom_range(0, 63));
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < BOUND && !bus.done; i++) tick();
        checks++;
        if (!bus.done) begin
            failures++;
            $display("FAIL %s timeout got done=%b exp=1", name, bus.done);
        end
    endtask

    task automatic apply_reset(input int hold);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < hold; i++) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.mine_map !== 64'h0 || bus.mine_count !== 9'd0) begin
            failures++;
            $display("FAIL reset_board got map=%h cnt=%0d exp 0/0", bus.mine_map, bus.mine_count);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got busy=%b done=%b exp 0/0", bus.busy, bus.done);
        end
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Request on the very first edge after reset release, safe tile 0.
    task automatic test_basic();
        start(0);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy got=%b exp=1", bus.busy);
        end
        wait_done("basic");
        checks++;
        if ($countones(bus.mine_map) != N || bus.mine_map[0] !== 1'b0
            || bus.mine_count !== 9'(N)) begin
            failures++;
            $display("FAIL basic_board got pop=%0d bit0=%b cnt=%0d exp %0d/0/%0d",
                     $countones(bus.mine_map), bus.mine_map[0], bus.mine_count, N, N);
        end
    endtask

    // Extra request while placing must not disturb the board; identical runs must match.
    task automatic test_ignore_and_determinism();
        logic [63:0] map_a;
        int d;
        int s;
        d = $urandom_range(0, 7);
        s = $urandom_range(0, 63);
        apply_reset(2);
        for (int i = 0; i < d; i++) tick();
        start(s);
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL ignore_busy got=%b exp=1", bus.busy);
        end
        start((s + 17) % 64);
        wait_done("ignore");
        map_a = bus.mine_map;
        apply_reset(2);
        for (int i = 0; i < d; i++) tick();
        start(s);
        wait_done("determinism");
        checks++;
        if (bus.mine_map !== map_a) begin
            failures++;
            $display("FAIL determinism got=%h exp=%h", bus.mine_map, map_a);
        end
    endtask

    // New request from a finished board with safe tile 37.
    task automatic test_regen();
        logic [63:0] prev;
        prev = bus.mine_map;
        start(37);
        checks++;
        if (bus.done !== 1'b0 || bus.mine_map !== 64'h0) begin
            failures++;
            $display("FAIL regen_clear got done=%b map=%h exp 0/0", bus.done, bus.mine_map);
        end
        wait_done("regen");
        checks++;
        if (bus.mine_map === prev || $countones(bus.mine_map) != N || bus.mine_map[37] !== 1'b0)
        begin
            failures++;
            $display("FAIL regen_board got map=%h prev=%h pop=%0d bit37=%b", bus.mine_map, prev,
                     $countones(bus.mine_map), bus.mine_map[37]);
        end
    endtask

    // Random safe tiles, idle gaps and stray requests during placement.
    task automatic test_random();
        int s;
        int i;
        for (int it = 0; it < 8; it++) begin
            s = $urandom_range(0, 63);
            for (int k = 0; k < int'($urandom_range(0, 4)); k++) tick();
            start(s);
            for (i = 0; i < BOUND && !bus.done; i++) begin
                bus.gen      = ($urandom_range(0, 3) == 0);
                bus.safe_idx = 6'($urandom_range(0, 63));
                tick();
            end
            bus.gen = 1'b0;
            checks++;
            if (!bus.done || bus.mine_map[s] !== 1'b0 || $countones(bus.mine_map) != N) begin
                failures++;
                $display("FAIL random it=%0d got done=%b safebit=%b pop=%0d exp 1/0/%0d", it,
                         bus.done, bus.mine_map[s], $countones(bus.mine_map), N);
            end
        end
    endtask

    // Asynchronous reset in the middle of placement.
    task automatic test_reset_mid_place();
        int i;
        start($urandom_range(0, 63));
        for (i = 0; i < BOUND && bus.mine_count != 9'd4; i++) tick();
        checks++;
        if (bus.mine_count !== 9'd4 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL midreset_reach got cnt=%0d busy=%b exp 4/1", bus.mine_count, bus.busy);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.mine_map !== 64'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_async got map=%h busy=%b done=%b exp 0/0/0", bus.mine_map,
                     bus.busy, bus.done);
        end
        model_reset();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.mine_count !== 9'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_idle got cnt=%0d busy=%b exp 0/0", bus.mine_count, bus.busy);
        end
        start(9);
        wait_done("midreset_rerun");
    endtask

    // Densest board: every tile but the safe one gets a mine.
    task automatic test_full63();
        logic [63:0] exp_map;
        int i;
        exp_map    = '1;
        exp_map[5] = 1'b0;
        bus63.gen      = 1'b1;
        bus63.safe_idx = 6'd5;
        tick();
        t63_safe       = 5;
        bus63.gen      = 1'b0;
        bus63.safe_idx = 6'd0;
        for (i = 0; i < BOUND && !bus63.done; i++) tick();
        checks++;
        if (bus63.done !== 1'b1 || bus63.mine_map !== exp_map || bus63.mine_count !== 9'd63) begin
            failures++;
            $display("FAIL full63 got done=%b map=%h cnt=%0d exp 1/%h/63", bus63.done,
                     bus63.mine_map, bus63.mine_count, exp_map);
        end
    endtask

    initial begin
        bus.gen        = 1'b0;
        bus.safe_idx   = 6'd0;
        bus63.gen      = 1'b0;
        bus63.safe_idx = 6'd0;
        t63_safe       = 0;
        model_reset();
        test_reset();
        test_basic();
        test_regen();
        test_ignore_and_determinism();
        test_random();
        test_reset_mid_place();
        test_full63();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
